tube_disp_arbiter: RTL and testbench
====================================

Name: tube_disp_arbiter

Overview:
- Shares the eight-digit seven-segment display write port between three requesters (0 = CPU store path, 1 = debug/PC monitor, 2 = switch echo).
- Drives the display's disp_ena/dv_addr/disp_data inputs with single-cycle writes.
- Enforces a minimum dwell time after each write so a value stays visible before another source may overwrite it.
- Sits between the bus/debug logic and the display driver in the pipelined CPU top level.

Parameters:
- NREQ, 3, number of requesters (fixed at 3 in this revision).
- TUBEADDR, 12'h000, address placed on dv_addr during a write; must match the display driver's address.
- HOLD_CYCLES, 100000, dwell cycles after a write before the next grant; legal range >= 1.
- HCW, 17, hold counter width; must satisfy 2^HCW > HOLD_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  3  per-requester write request, level; held until acked.
- req_data  in  96  packed write data; requester i uses bits [32*i+31:32*i].
- ack  out  3  one-hot one-cycle grant/accept pulse.
- disp_ena  out  1  display write strobe, one cycle.
- dv_addr  out  12  display address.
- disp_data  out  32  display data.
- busy  out  1  high in WRITE or HOLD.
- owner  out  2  index of last granted requester.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n: sampled only at a rising clk edge.
- Reset values:
  - Registered outputs: ack=0, disp_ena=0, dv_addr=0, disp_data=0, owner=0.
  - busy is derived from the state, so it is 0 in IDLE.
  - state=IDLE, hold counter=0, round-robin pointer last=2 so requester 0 is checked first.
- Reset mid-WRITE or mid-HOLD:
  - Aborts the operation and returns to IDLE on that edge.
  - A pending ack is not issued.
- FSM states:
  - IDLE: if req != 0, pick the winner by round-robin, searching from (last+1) mod 3 upward with wrap. On the same edge:
    - disp_ena<=1, dv_addr<=TUBEADDR, disp_data<=winner's data sampled on that edge.
    - ack[winner]<=1, owner<=winner, last<=winner.
    - go to WRITE.
  - IDLE with req == 0: stay; outputs hold their values except disp_ena and ack, which are 0.
  - WRITE (one cycle, strobes visible): next edge disp_ena<=0, ack<=0, counter<=HOLD_CYCLES-1, go to HOLD.
  - HOLD: decrement the counter each cycle. When the counter==0, go to IDLE. Requests are ignored in HOLD.
- Latency:
  - Request seen in IDLE at edge n produces disp_ena and ack high during cycle n+1.
  - Back-to-back writes are spaced exactly HOLD_CYCLES+2 cycles apart (strobe to strobe).
- Requester rules:
  - Keep req high and data stable until ack is seen.
  - Drop req the cycle after ack, or earlier: req is sampled only in IDLE.
  - Dropping req before a grant cancels the request silently.
- dv_addr and disp_data stay at their last written values between writes; only disp_ena qualifies them.
- Simultaneous requests: exactly one is granted per write. No requester waits more than 2 other grants.

Optional Feature:
- Macro TUBE_ARB_CPU_PREEMPT_EN.
- Defined:
  - Requester 0 always wins in IDLE regardless of the pointer.
  - req[0] seen in HOLD ends HOLD immediately and the write is issued on that edge: WRITE entry, same output updates as the IDLE grant.
  - Requesters 1 and 2 keep round-robin between themselves.
- Undefined: pure round-robin, and HOLD applies to everyone.

Decomposition:
- Shared package tube_pkg:
  - state encodings IDLE=2'd0, WRITE=2'd1, HOLD=2'd2;
  - TUBEADDR constant;
  - requester index constants REQ_CPU=0, REQ_DBG=1, REQ_SW=2.
- Sub-module rr_pick3: combinational round-robin picker. Inputs req[2:0], last[1:0], plus a prio0 input for the macro. Outputs a one-hot grant and the index.
- FSM, counter and output registers stay in tube_disp_arbiter.

Test Plan (HOLD_CYCLES=4 for sim):
- Reset: assert rst_n=0 for 2 edges with req=3'b111 -> all outputs 0, busy=0, no ack during reset.
- Single request: req=3'b010, data1=32'h1234ABCD -> one cycle later ack=3'b010, disp_ena=1, dv_addr=12'h000, disp_data=32'h1234ABCD. Then busy stays high for 5 cycles (1 WRITE + 4 HOLD) and no second strobe.
- Contention: req=3'b111 held, each requester dropping after its ack -> grant order 0,1,2. Strobes 6 cycles apart.
- Starvation check: req[0] and req[2] held permanently -> grants alternate 0,2,0,2.
- Mid-op reset: rst_n=0 during HOLD (counter=2) -> next edge state IDLE, busy=0. A req seen after release is granted with normal 1-cycle latency.
- Macro on: req[2] granted, then req[0] asserted during HOLD -> disp_ena with data0 on the following cycle, ack=3'b001. Macro off: same stimulus waits for HOLD to expire.

Source files
------------

// File: rtl/tube_pkg.sv
// Shared types and constants for the seven-segment display write arbiter.
package tube_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [11:0] TUBEADDR = 12'h000;

   localparam logic [1:0] REQ_CPU = 2'd0;
   localparam logic [1:0] REQ_DBG = 2'd1;
   localparam logic [1:0] REQ_SW  = 2'd2;

   // Successor of a requester index in the three-way ring; out-of-range values restart at 0.
   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i >= 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

endpackage

// File: rtl/tube_disp_arbiter_if.sv
// Requester/display bundle: requests and packed data in, grant strobes and display write port out.
interface tube_disp_arbiter_if;

   logic [2:0]  req;
   logic [95:0] req_data;
   logic [2:0]  ack;
   logic        disp_ena;
   logic [11:0] dv_addr;
   logic [31:0] disp_data;
   logic        busy;
   logic [1:0]  owner;

   modport master (
      output req, req_data,
      input  ack, disp_ena, dv_addr, disp_data, busy, owner
   );

   modport slave (
      input  req, req_data,
      output ack, disp_ena, dv_addr, disp_data, busy, owner
   );

endinterface

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker; prio0 lets requester 0 override the rotation.
module rr_pick3
   import tube_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   input  logic       prio0,
   output logic [2:0] grant,
   output logic [1:0] idx
);

   logic [1:0] c0;
   logic [1:0] c1;
   logic [1:0] c2;
   logic       any_req;

   assign c0      = next_idx(last);
   assign c1      = next_idx(c0);
   assign c2      = next_idx(c1);
   assign any_req = |req;

   always_comb begin
      idx = c0;
      if (prio0 && req[REQ_CPU])
         idx = REQ_CPU;
      else if (req[c0])
         idx = c0;
      else if (req[c1])
         idx = c1;
      else if (req[c2])
         idx = c2;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_grant
         assign grant[gi] = any_req && (idx == 2'(gi));
      end
   endgenerate

endmodule

// File: rtl/tube_disp_arbiter.sv
// Arbitrates three requesters onto the display write port with a dwell period after each write.
// Define TUBE_ARB_CPU_PREEMPT_EN to give requester 0 absolute priority, including cutting HOLD short.
module tube_disp_arbiter #(
   parameter int          NREQ        = 3,
   parameter logic [11:0] TUBEADDR    = tube_pkg::TUBEADDR,
   parameter int          HOLD_CYCLES = 100000,
   parameter int          HCW         = 17
) (
   input  logic               clk,
   input  logic               rst_n,
   tube_disp_arbiter_if.slave bus
);

   import tube_pkg::*;

   localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

   state_t          state_reg;
   logic [HCW-1:0]  cnt_reg;
   logic [1:0]      last_reg;
   logic [1:0]      owner_reg;
   logic [NREQ-1:0] ack_reg;
   logic            ena_reg;
   logic [11:0]     addr_reg;
   logic [31:0]     data_reg;

   logic [2:0]      pick_grant;
   logic [1:0]      pick_idx;
   logic [31:0]     win_data;
   logic            prio0;
   logic            preempt;
   logic            do_grant;

`ifdef TUBE_ARB_CPU_PREEMPT_EN
   assign prio0   = 1'b1;
   assign preempt = bus.req[REQ_CPU];
`else
   assign prio0   = 1'b0;
   assign preempt = 1'b0;
`endif

   rr_pick3 u_pick (
      .req   (bus.req),
      .last  (last_reg),
      .prio0 (prio0),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   assign win_data = bus.req_data[32*pick_idx +: 32];

   // A grant starts from IDLE, or from HOLD only when the CPU preempts the dwell.
   assign do_grant = ((state_reg == IDLE) && (|bus.req)) ||
                     ((state_reg == HOLD) && preempt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         last_reg  <= REQ_SW;
         owner_reg <= '0;
         ack_reg   <= '0;
         ena_reg   <= 1'b0;
         addr_reg  <= '0;
         data_reg  <= '0;
      end else begin
         ack_reg <= '0;
         ena_reg <= 1'b0;
         if (do_grant) begin
            ena_reg   <= 1'b1;
            addr_reg  <= TUBEADDR;
            data_reg  <= win_data;
            ack_reg   <= NREQ'(pick_grant);
            owner_reg <= pick_idx;
            last_reg  <= pick_idx;
            state_reg <= WRITE;
         end else begin
            case (state_reg)
               WRITE: begin
                  cnt_reg   <= HOLD_LOAD;
                  state_reg <= HOLD;
               end
               HOLD: begin
                  if (cnt_reg == '0)
                     state_reg <= IDLE;
                  else
                     cnt_reg <= cnt_reg - 1'b1;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign bus.ack       = 3'(ack_reg);
   assign bus.disp_ena  = ena_reg;
   assign bus.dv_addr   = addr_reg;
   assign bus.disp_data = data_reg;
   assign bus.owner     = owner_reg;
   assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_tube_disp_arbiter.sv
// Self-checking bench for tube_disp_arbiter: vector table, hand sequences and a randomized model run.
module tb_tube_disp_arbiter;

   import tube_pkg::*;

   localparam int HOLD = 4;
`ifdef TUBE_ARB_CPU_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tube_disp_arbiter_if bus ();

   tube_disp_arbiter #(
      .NREQ        (3),
      .TUBEADDR    (12'h000),
      .HOLD_CYCLES (HOLD),
      .HCW         (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  req;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [2:0]  exp_ack;
      logic [31:0] exp_data;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_strobe(output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!bus.disp_ena && cyc < 64);
      if (!bus.disp_ena) begin
         n_cmp++;
         n_bad++;
         $display("FAIL strobe_timeout: got no disp_ena within %0d cycles, expected one", cyc);
      end
   endtask

   task automatic drain();
      int k;
      bus.req = 3'b000;
      k = 0;
      do begin
         step();
         k++;
      end while (bus.busy && k < 64);
      check("drain_busy", 32'(bus.busy), 32'd0);
   endtask

   function automatic int onehot_idx(input logic [2:0] oh);
      return oh[2] ? 2 : (oh[1] ? 1 : 0);
   endfunction

   // Reference winner: first asserted requester after the previous winner, CPU first when preempting.
   function automatic int model_pick(input logic [2:0] r, input int lst);
      if (PREEMPT && r[0])
         return 0;
      for (int k = 1; k <= 3; k++) begin
         if (r[(lst + k) % 3])
            return (lst + k) % 3;
      end
      return 0;
   endfunction

   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          cyc;
      logic [31:0] dw[3];
      logic [2:0]  ord[4];
      logic [2:0]  rq;
      logic [31:0] dd[3];
      int          cool;
      int          mlast;
      int          w;
      int          pend[3];
      logic [2:0]  e_ack;
      logic        e_ena;
      logic [31:0] e_data;
      logic [1:0]  e_owner;

      vecs[0] = '{3'b010, 32'hA0A0_0001, 32'h1234_ABCD, 32'hC0C0_0001, 3'b010, 32'h1234_ABCD};
      vecs[1] = '{3'b111, 32'hA0A0_0002, 32'hB0B0_0002, 32'hC0C0_0002,
                  PREEMPT ? 3'b001 : 3'b100, PREEMPT ? 32'hA0A0_0002 : 32'hC0C0_0002};
      vecs[2] = '{3'b011, 32'hA0A0_0003, 32'hB0B0_0003, 32'hC0C0_0003, 3'b001, 32'hA0A0_0003};
      vecs[3] = '{3'b101, 32'hA0A0_0004, 32'hB0B0_0004, 32'hC0C0_0004,
                  PREEMPT ? 3'b001 : 3'b100, PREEMPT ? 32'hA0A0_0004 : 32'hC0C0_0004};
      vecs[4] = '{3'b001, 32'hA0A0_0005, 32'hB0B0_0005, 32'hC0C0_0005, 3'b001, 32'hA0A0_0005};
      vecs[5] = '{3'b110, 32'hA0A0_0006, 32'hB0B0_0006, 32'hC0C0_0006, 3'b010, 32'hB0B0_0006};

      bus.req      = 3'b111;
      bus.req_data = '0;

      // Reset held with every request asserted: no grant may escape.
      rst_n = 1'b0;
      step();
      check("rst_ack_e1", 32'(bus.ack), 32'd0);
      step();
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_ena", 32'(bus.disp_ena), 32'd0);
      check("rst_addr", 32'(bus.dv_addr), 32'd0);
      check("rst_data", bus.disp_data, 32'd0);
      check("rst_owner", 32'(bus.owner), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      bus.req = 3'b000;
      rst_n = 1'b1;
      step();

      // Table: one grant per row from IDLE, pointer carried across rows.
      for (int i = 0; i < 6; i++) begin
         bus.req      = vecs[i].req;
         bus.req_data = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
         step();
         $display("vec %0d: req=%b ack=%b data=%h", i, vecs[i].req, bus.ack, bus.disp_data);
         check("vec_ack", 32'(bus.ack), 32'(vecs[i].exp_ack));
         check("vec_ena", 32'(bus.disp_ena), 32'd1);
         check("vec_addr", 32'(bus.dv_addr), 32'h000);
         check("vec_data", bus.disp_data, vecs[i].exp_data);
         check("vec_owner", 32'(bus.owner), 32'(onehot_idx(vecs[i].exp_ack)));
         check("vec_busy", 32'(bus.busy), 32'd1);
         bus.req = 3'b000;
         for (int k = 0; k < HOLD; k++) begin
            step();
            check("vec_hold", {29'd0, bus.disp_ena, bus.busy, |bus.ack}, 32'b010);
         end
         step();
         check("vec_idle", 32'(bus.busy), 32'd0);
         check("vec_keep_data", bus.disp_data, vecs[i].exp_data);
      end

      // Contention: all three held, each dropping after its ack.
      do_reset();
      dw[0] = 32'h0000_00C0;
      dw[1] = 32'h0000_00D1;
      dw[2] = 32'h0000_00E2;
      bus.req_data = {dw[2], dw[1], dw[0]};
      bus.req      = 3'b111;
      ord[0] = 3'b001;
      ord[1] = 3'b010;
      ord[2] = 3'b100;
      for (int k = 0; k < 3; k++) begin
         wait_strobe(cyc);
         $display("contend %0d: ack=%b after %0d cycles", k, bus.ack, cyc);
         check("cont_ack", 32'(bus.ack), 32'(ord[k]));
         check("cont_data", bus.disp_data, dw[onehot_idx(ord[k])]);
         if (k > 0)
            check("cont_spacing", 32'(cyc), 32'(HOLD + 2));
         bus.req = bus.req & ~bus.ack;
      end
      drain();

      // Requesters 0 and 2 held permanently.
      do_reset();
      bus.req = 3'b101;
      for (int k = 0; k < 4; k++) begin
         wait_strobe(cyc);
         $display("starve %0d: ack=%b after %0d cycles", k, bus.ack, cyc);
         if (PREEMPT)
            check("starve_ack", 32'(bus.ack), 32'b001);
         else
            check("starve_ack", 32'(bus.ack), (k % 2 == 0) ? 32'b001 : 32'b100);
         if (k > 0)
            check("starve_spacing", 32'(cyc), PREEMPT ? 32'd2 : 32'(HOLD + 2));
      end
      drain();

      // Reset in the middle of HOLD, then a normal grant.
      do_reset();
      bus.req = 3'b010;
      step();
      check("midrst_grant", 32'(bus.ack), 32'b010);
      bus.req = 3'b000;
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_ena", 32'(bus.disp_ena), 32'd0);
      check("midrst_owner", 32'(bus.owner), 32'd0);
      bus.req = 3'b100;
      step();
      $display("midrst regrant: ack=%b data=%h", bus.ack, bus.disp_data);
      check("midrst_regrant", 32'(bus.ack), 32'b100);
      check("midrst_regrant_ena", 32'(bus.disp_ena), 32'd1);
      drain();

      // CPU request arriving during another requester's HOLD.
      do_reset();
      bus.req_data = {32'h2222_2222, 32'h1111_1111, 32'h0BAD_CAFE};
      bus.req      = 3'b100;
      step();
      check("pre_first", 32'(bus.ack), 32'b100);
      bus.req = 3'b000;
      step();
      bus.req = 3'b001;
      wait_strobe(cyc);
      $display("cpu during hold: ack=%b after %0d cycles", bus.ack, cyc);
      check("pre_ack", 32'(bus.ack), 32'b001);
      check("pre_data", bus.disp_data, 32'h0BAD_CAFE);
      check("pre_latency", 32'(cyc), PREEMPT ? 32'd1 : 32'(HOLD + 1));
      drain();

      // Randomized requesters against the timeline model.
      do_reset();
      rq      = 3'b000;
      cool    = 0;
      mlast   = 2;
      e_data  = 32'd0;
      e_owner = 2'd0;
      for (int i = 0; i < 3; i++) begin
         dd[i]   = 32'd0;
         pend[i] = 0;
      end
      for (int it = 0; it < 600; it++) begin
         bus.req      = rq;
         bus.req_data = {dd[2], dd[1], dd[0]};
         step();
         e_ack = 3'b000;
         e_ena = 1'b0;
         if (rq != 3'b000 && (cool == 0 || (PREEMPT && rq[0] && cool <= HOLD))) begin
            w = model_pick(rq, mlast);
            e_ack[w] = 1'b1;
            e_ena    = 1'b1;
            e_data   = dd[w];
            e_owner  = 2'(w);
            mlast    = w;
            cool     = HOLD + 1;
            if (!PREEMPT)
               check("rnd_fair", 32'(pend[w] <= 2), 32'd1);
            for (int j = 0; j < 3; j++)
               if (j != w && rq[j])
                  pend[j]++;
            pend[w] = 0;
            $display("rnd grant: req=%b winner=%0d data=%h", rq, w, dd[w]);
         end else if (cool > 0) begin
            cool--;
         end
         check("rnd_ack", 32'(bus.ack), 32'(e_ack));
         check("rnd_ena", 32'(bus.disp_ena), 32'(e_ena));
         check("rnd_data", bus.disp_data, e_data);
         check("rnd_owner", 32'(bus.owner), 32'(e_owner));
         check("rnd_busy", 32'(bus.busy), 32'(cool > 0));
         for (int i = 0; i < 3; i++) begin
            if (e_ack[i]) begin
               rq[i] = 1'b0;
            end else if (!rq[i]) begin
               if ($urandom_range(3) == 0) begin
                  rq[i]   = 1'b1;
                  dd[i]   = $urandom;
                  pend[i] = 0;
               end
            end else if ($urandom_range(15) == 0) begin
               rq[i]   = 1'b0;
               pend[i] = 0;
            end
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
